// File: rtl/pipeline_defs.sv
// Shared definitions for the pipeline stall controller: register-zero constant,
// mul/div sequencer state encoding, default latency and the hazard match helper.
package pipeline_defs;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         DEFAULT_MD_LATENCY = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    // A source register only creates a hazard when it is actually read,
    // is not $0, and equals the producer's destination.
    function automatic logic src_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] dest);
        return uses && (src != REG_ZERO) && (src == dest);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide busy sequencer. Launches the unit on an accepted
// request, counts down the latency, then spends one cycle in DONE while HI/LO
// become valid before returning to IDLE.
module muldiv_sequencer
    import pipeline_defs::*;
#(
    parameter int MD_LATENCY = DEFAULT_MD_LATENCY
) (
    input  logic clock,
    input  logic reset,
    input  logic start_req,
    output logic busy,
    output logic done,
    output logic md_start
);

    localparam logic [7:0] LOAD_VALUE = 8'(MD_LATENCY - 1);

    md_state_e  state;
    md_state_e  state_next;
    logic [7:0] count;
    logic [7:0] count_next;

    // State and down-counter registers; reset aborts any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= 8'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next-state, counter and launch pulse; no launch is issued while in reset.
    always_comb begin
        state_next = state;
        count_next = count;
        md_start   = 1'b0;
        case (state)
            IDLE: begin
                if (start_req && !reset) begin
                    md_start   = 1'b1;
                    state_next = BUSY;
                    count_next = LOAD_VALUE;
                end
            end
            BUSY: begin
                count_next = count - 8'd1;
                if (count == 8'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central hazard and stall sequencer for the five-stage pipeline. Detects
// load-use, branch-operand and HI/LO hazards, drives PC / IF/ID / ID/EX
// hold and flush controls, owns the mul/div sequencer and counts stall cycles.
module pipeline_stall_controller
    import pipeline_defs::*;
#(
    parameter int MD_LATENCY = DEFAULT_MD_LATENCY,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 id_is_branch,
    input  logic                 id_is_muldiv,
    input  logic                 id_reads_hilo,
    input  logic                 branch_taken,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_write_reg,
    input  logic                 mem_mem_read,
    input  logic [4:0]           mem_write_reg,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 md_start,
    output logic                 md_busy,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    logic ex_match;
    logic mem_match;
    logic load_use;
    logic branch_hz;
    logic md_hz;
    logic stall;
    logic start_req;
    logic md_run;
    logic md_done;

    // Hazard detection: a branch needs its operands in ID, so it also waits on
    // ALU results in EX and loads in MEM; everything else only waits on loads in EX.
    always_comb begin
        ex_match  = src_match(id_uses_rs, id_rs, ex_write_reg)
                  | src_match(id_uses_rt, id_rt, ex_write_reg);
        mem_match = src_match(id_uses_rs, id_rs, mem_write_reg)
                  | src_match(id_uses_rt, id_rt, mem_write_reg);
        load_use  = ex_mem_read & ex_match;
        branch_hz = id_is_branch & ((ex_reg_write & ex_match) | (mem_mem_read & mem_match));
        md_hz     = md_busy & (id_reads_hilo | id_is_muldiv);
        stall     = load_use | branch_hz | md_hz;
        start_req = id_is_muldiv & ~stall;
    end

    muldiv_sequencer #(
        .MD_LATENCY(MD_LATENCY)
    ) u_muldiv_sequencer (
        .clock    (clock),
        .reset    (reset),
        .start_req(start_req),
        .busy     (md_run),
        .done     (md_done),
        .md_start (md_start)
    );

    // HI/LO stay pending through DONE, so both states count as busy.
    assign md_busy     = md_run | md_done;
    assign pc_write    = ~stall;
    assign if_id_write = ~stall;
    assign id_ex_flush = stall;
    assign if_id_flush = branch_taken & ~stall;

    // Stall-cycle performance counter, wrapping naturally at its width.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed scenarios followed
// by randomized traffic, all checked against a cycle-indexed reference model.
module tb_pipeline_stall_controller;

    localparam int LAT = 4;
    localparam int CW  = 4;

    logic          clock;
    logic          reset;
    logic [4:0]    id_rs, id_rt;
    logic          id_uses_rs, id_uses_rt;
    logic          id_is_branch, id_is_muldiv, id_reads_hilo, branch_taken;
    logic          ex_reg_write, ex_mem_read;
    logic [4:0]    ex_write_reg;
    logic          mem_mem_read;
    logic [4:0]    mem_write_reg;
    logic          pc_write, if_id_write, if_id_flush, id_ex_flush, md_start, md_busy;
    logic [CW-1:0] stall_cycles;

    int n_compared;
    int n_mismatched;

    // reference model state: current cycle index, last cycle HI/LO are pending, counter
    int cyc;
    int md_end;
    int cnt_model;

    pipeline_stall_controller #(
        .MD_LATENCY(LAT),
        .CNT_WIDTH (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_is_branch (id_is_branch),
        .id_is_muldiv (id_is_muldiv),
        .id_reads_hilo(id_reads_hilo),
        .branch_taken (branch_taken),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_write_reg (ex_write_reg),
        .mem_mem_read (mem_mem_read),
        .mem_write_reg(mem_write_reg),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, observed, expected);
        end
    endtask

    // does the producer destination hit any register the ID instruction actually reads
    function automatic bit reads_reg(input logic [4:0] dest);
        bit hit;
        logic [4:0] srcs [2];
        bit         used [2];
        srcs[0] = id_rs; used[0] = id_uses_rs;
        srcs[1] = id_rt; used[1] = id_uses_rt;
        hit = 0;
        for (int i = 0; i < 2; i++)
            if (used[i] && srcs[i] != 0 && srcs[i] == dest) hit = 1;
        return hit;
    endfunction

    // one clock cycle: inputs already driven; check mid-cycle, then advance the model
    task automatic apply_stimulus();
        bit hilo_pending, stall_m, start_m;
        @(negedge clock);
        #1;
        hilo_pending = (cyc <= md_end);
        stall_m = (ex_mem_read && reads_reg(ex_write_reg))
               || (id_is_branch && ex_reg_write && reads_reg(ex_write_reg))
               || (id_is_branch && mem_mem_read && reads_reg(mem_write_reg))
               || (hilo_pending && (id_reads_hilo || id_is_muldiv));
        start_m = !reset && !hilo_pending && id_is_muldiv && !stall_m;

        check_output("pc_write",     32'(pc_write),     32'(!stall_m));
        check_output("if_id_write",  32'(if_id_write),  32'(!stall_m));
        check_output("id_ex_flush",  32'(id_ex_flush),  32'(stall_m));
        check_output("if_id_flush",  32'(if_id_flush),  32'(branch_taken && !stall_m));
        check_output("md_start",     32'(md_start),     32'(start_m));
        check_output("md_busy",      32'(md_busy),      32'(hilo_pending));
        check_output("stall_cycles", 32'(stall_cycles), 32'(cnt_model));

        if (reset) begin
            cnt_model = 0;
            if (md_end > cyc) md_end = cyc;
        end else begin
            if (stall_m) cnt_model = (cnt_model + 1) % (1 << CW);
            if (start_m) md_end = cyc + LAT;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_is_branch = 0; id_is_muldiv = 0; id_reads_hilo = 0; branch_taken = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_write_reg = 0;
        mem_mem_read = 0; mem_write_reg = 0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom_range(1, 31));
        endcase
    endfunction

    initial begin
        n_compared = 0; n_mismatched = 0;
        cyc = 0; md_end = -1; cnt_model = 0;
        clear_inputs();
        reset = 1;
        @(posedge clock);
        #1;
        apply_stimulus();
        reset = 0;

        // load-use on rs
        ex_mem_read = 1; ex_write_reg = 8; id_rs = 8; id_uses_rs = 1;
        apply_stimulus();
        clear_inputs();
        apply_stimulus();

        // $0 never hazards
        ex_mem_read = 1; ex_write_reg = 0; id_rs = 0; id_uses_rs = 1;
        apply_stimulus();
        clear_inputs();

        // branch after load: two stall cycles then the flush
        id_is_branch = 1; id_rt = 9; id_uses_rt = 1;
        ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = 9;
        apply_stimulus();
        ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
        mem_mem_read = 1; mem_write_reg = 9;
        apply_stimulus();
        mem_mem_read = 0; mem_write_reg = 0; branch_taken = 1;
        apply_stimulus();
        clear_inputs();

        // mul/div followed by mfhi held in ID
        id_is_muldiv = 1;
        apply_stimulus();
        id_is_muldiv = 0; id_reads_hilo = 1;
        repeat (5) apply_stimulus();
        clear_inputs();
        apply_stimulus();

        // reset mid-operation
        id_is_muldiv = 1;
        apply_stimulus();
        id_is_muldiv = 0; id_reads_hilo = 1;
        apply_stimulus();
        reset = 1;
        apply_stimulus();
        reset = 0;
        apply_stimulus();
        clear_inputs();

        // counter wrap: 17 held load-use cycles from zero
        reset = 1;
        apply_stimulus();
        reset = 0;
        ex_mem_read = 1; ex_write_reg = 8; id_rs = 8; id_uses_rs = 1;
        repeat (17) apply_stimulus();
        clear_inputs();
        apply_stimulus();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            id_rs         = pick_reg();
            id_rt         = pick_reg();
            id_uses_rs    = 1'($urandom);
            id_uses_rt    = 1'($urandom);
            id_is_branch  = ($urandom_range(0, 3) == 0);
            id_is_muldiv  = ($urandom_range(0, 5) == 0);
            id_reads_hilo = ($urandom_range(0, 4) == 0);
            branch_taken  = 1'($urandom);
            ex_reg_write  = 1'($urandom);
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_write_reg  = pick_reg();
            mem_mem_read  = ($urandom_range(0, 2) == 0);
            mem_write_reg = pick_reg();
            apply_stimulus();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central hazard and stall sequencer for the five-stage pipeline.
- Drives the write enables and flush controls of the PC register, the IF/ID register and the ID/EX register, so these registers hold or bubble on load-use hazards, branch-operand hazards and taken branches.
- Owns the multi-cycle multiply/divide busy FSM and stalls ID while HI/LO results are pending.
- Keeps a 32-bit stall-cycle performance counter.

Parameters:
- MD_LATENCY, 32, cycles from md_start until HI/LO are valid; legal range 2..255.
- CNT_WIDTH, 32, width of stall_cycles.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID holds beq/bne; its operands are resolved in ID.
- id_is_muldiv  in  1  ID holds mult/multu/div/divu.
- id_reads_hilo  in  1  ID holds mfhi/mflo.
- branch_taken  in  1  branch comparison in ID is true.
- ex_reg_write  in  1  EX instruction writes the register file.
- ex_mem_read  in  1  EX instruction is a load.
- ex_write_reg  in  5  destination register of the EX instruction.
- mem_mem_read  in  1  MEM instruction is a load.
- mem_write_reg  in  5  destination register of the MEM instruction.
- pc_write  out  1  write enable of the PC register.
- if_id_write  out  1  write enable of the IF/ID register.
- if_id_flush  out  1  clear IF/ID on the next edge.
- id_ex_flush  out  1  load a bubble into ID/EX on the next edge.
- md_start  out  1  one-cycle pulse that launches the mul/div unit.
- md_busy  out  1  a mul/div operation is in flight.
- stall_cycles  out  CNT_WIDTH  count of cycles with stall asserted.

Behaviour:
- Clock and reset: one clock, "clock"; reset is synchronous and active-high, named "reset".
- Hazard match (combinational): srcmatch(r) = uses_r & (r != 0) & (r == dest). Register $0 never causes a hazard.
- load_use = ex_mem_read & (srcmatch(rs, ex_write_reg) | srcmatch(rt, ex_write_reg)).
- branch_hz = id_is_branch & ((ex_reg_write & match on ex_write_reg) | (mem_mem_read & match on mem_write_reg)).
  - ALU result in EX: 1 stall cycle.
  - Load in EX: 2 stall cycles.
  - Load in MEM: 1 stall cycle.
- md_hz = (state != IDLE) & (id_reads_hilo | id_is_muldiv).
- stall = load_use | branch_hz | md_hz.
- Output equations:
  - pc_write = if_id_write = ~stall.
  - id_ex_flush = stall.
  - if_id_flush = branch_taken & ~stall. A stalled branch is re-evaluated next cycle, so no flush is issued while stalled.
- Mul/div FSM, states IDLE, BUSY, DONE:
  - IDLE -> BUSY when id_is_muldiv & ~stall. md_start = 1 in that cycle only; counter loads MD_LATENCY-1.
  - BUSY: counter decrements each cycle; at counter == 1 -> DONE.
  - DONE: exactly 1 cycle, HI/LO valid, then -> IDLE. md_hz remains true in DONE, so mfhi issues the cycle after DONE.
  - md_busy = (state != IDLE).
  - Latency: md_start at cycle t; first non-stalled mfhi is in ID at t+MD_LATENCY+1.
- stall_cycles increments by 1 on every cycle with stall = 1. It wraps modulo 2^CNT_WIDTH.
- Reset:
  - state = IDLE, counter = 0, stall_cycles = 0.
  - With hazard inputs low, outputs read: pc_write = 1, if_id_write = 1, if_id_flush = 0, id_ex_flush = 0, md_start = 0, md_busy = 0.
  - Reset during BUSY aborts the operation next edge. No md_start is issued in the reset cycle.
- Simultaneous events:
  - load_use and md_hz together are one stall cycle; stall_cycles counts +1, not +2.
  - branch_taken together with stall: no flush.
  - id_is_muldiv while BUSY stalls; it does not restart the unit.

Decomposition:
- Shared package/header (pipeline_defs):
  - REG_ZERO = 5'd0.
  - MD state encodings IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2.
  - Default MD_LATENCY.
- One sub-module: muldiv_sequencer, holding the FSM and down-counter. Its ports are clock, reset, start_req, busy, done, md_start.
- Hazard detection stays inline in pipeline_stall_controller.

Test Plan:
- Load-use: ex_mem_read = 1, ex_write_reg = 8, id_rs = 8, id_uses_rs = 1 -> exactly 1 cycle of pc_write = 0, if_id_write = 0, id_ex_flush = 1; stall_cycles = 1.
- Zero register: ex_mem_read = 1, ex_write_reg = 0, id_rs = 0, id_uses_rs = 1 -> no stall.
- Branch after load:
  - cycle 1: ex_mem_read = 1, ex_write_reg = 9, id_is_branch = 1, id_rt = 9, id_uses_rt = 1 -> stall.
  - cycle 2: mem_mem_read = 1, mem_write_reg = 9 -> stall.
  - cycle 3: branch_taken = 1 -> stall = 0 and if_id_flush = 1; stall_cycles = 2.
- Mul/div, MD_LATENCY = 4:
  - id_is_muldiv = 1 at t0 -> md_start pulse at t0, md_busy for t0+1..t0+4.
  - mfhi held in ID from t0+1 stalls through t0+4 and issues at t0+5.
- Reset mid-operation: reset = 1 at t0+2 of a mul/div -> next cycle md_busy = 0, stall_cycles = 0, pc_write = 1.
- Counter wrap: with CNT_WIDTH = 4, hold load_use for 17 cycles -> stall_cycles = 1.
